// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-wide synchronous-read RAM: sub-word loads, read-modify-write sub-word stores.
// Define MISALIGN_TRAP_EN to flag misaligned requests instead of silently aligning them.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_addr;
  logic [1:0]         r_size;
  logic               r_signed;
  logic [1:0]         r_off;
  logic [15:0]        r_wdata;
  logic               r_isLoad;

  logic               w_isWord;
  logic               w_isHalf;
  logic               w_misal;
  logic               w_trap;
  logic [1:0]         w_off;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_ext;
  logic [31:0]        w_merged;
  logic               w_unused;

  assign w_unused = ^req_addr[31:ADDR_W+2];
  assign w_isWord = req_size[1];
  assign w_isHalf = (req_size == 2'b01);
  assign w_misal  = (w_isHalf && req_addr[0]) || (w_isWord && (req_addr[1:0] != 2'b00));

`ifdef MISALIGN_TRAP_EN
  assign w_trap = w_misal;
  assign w_off  = req_addr[1:0];
`else
  // Without trapping, the offending low address bits are simply dropped.
  assign w_trap = 1'b0;
  assign w_off  = w_isWord ? 2'b00 : (w_isHalf ? {req_addr[1], 1'b0} : req_addr[1:0]);
`endif

  assign w_byte = ram_dout[{r_off, 3'b000} +: 8];
  assign w_half = ram_dout[{r_off[1], 4'b0000} +: 16];

  always_comb begin
    w_ext = ram_dout;
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = ram_dout;
    endcase
  end

  always_comb begin
    w_merged = ram_dout;
    if (r_size == 2'b00)
      w_merged[{r_off, 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_off[1], 4'b0000} +: 16] = r_wdata;
  end

  always_comb begin
    w_next      = r_state;
    stall       = 1'b0;
    ram_we      = 1'b0;
    ram_din     = req_wdata;
    ram_addr    = r_addr;
    misalign    = 1'b0;
    rdata_valid = 1'b0;
    case (r_state)
      IDLE: begin
        ram_addr = req_addr[ADDR_W+1:2];
        if (req_valid) begin
          if (w_trap) begin
            misalign = 1'b1;
          end else if (req_we && w_isWord) begin
            ram_we = 1'b1;
          end else begin
            stall  = 1'b1;
            w_next = req_we ? RMW : LOAD;
          end
        end
      end
      LOAD: begin
        stall  = 1'b1;
        w_next = DONE;
      end
      RMW: begin
        stall   = 1'b1;
        ram_we  = 1'b1;
        ram_din = w_merged;
        w_next  = DONE;
      end
      DONE: begin
        rdata_valid = r_isLoad;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
    // Reset overrides everything so an in-flight RMW never writes a partial word.
    if (rst) begin
      w_next      = IDLE;
      stall       = 1'b0;
      ram_we      = 1'b0;
      misalign    = 1'b0;
      rdata_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      rdata    <= 32'h0;
      r_addr   <= '0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_off    <= 2'b00;
      r_wdata  <= 16'h0;
      r_isLoad <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD)
        rdata <= w_ext;
      if (r_state == IDLE) begin
        r_addr   <= req_addr[ADDR_W+1:2];
        r_size   <= w_isWord ? 2'b10 : req_size;
        r_signed <= req_signed;
        r_off    <= w_off;
        r_wdata  <= req_wdata[15:0];
        r_isLoad <= ~req_we;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a word-array reference model predicts RAM writes and load results,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_mem_access_unit;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              reqValid;
  logic              reqWe;
  logic [1:0]        reqSize;
  logic              reqSigned;
  logic [31:0]       reqAddr;
  logic [31:0]       reqWdata;
  logic              stall;
  logic [31:0]       rdata;
  logic              rdataValid;
  logic              misalign;
  logic [ADDR_W-1:0] ramAddr;
  logic [31:0]       ramDin;
  logic              ramWe;
  logic [31:0]       ramDout;
  logic              tbInit;

  logic [31:0] ram   [0:DEPTH-1];
  logic [31:0] model [0:DEPTH-1];
  logic [41:0] wrQ [$];
  logic [31:0] ldQ [$];
  logic [41:0] monW;
  logic [31:0] monL;
  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_we(reqWe), .req_size(reqSize),
    .req_signed(reqSigned), .req_addr(reqAddr), .req_wdata(reqWdata), .stall(stall),
    .rdata(rdata), .rdata_valid(rdataValid), .misalign(misalign), .ram_addr(ramAddr),
    .ram_din(ramDin), .ram_we(ramWe), .ram_dout(ramDout)
  );

  always #5 clk = ~clk;

  // Environment RAM: synchronous read, read-before-write, filled with a hash pattern at start.
  always @(posedge clk) begin
    if (tbInit) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 32'h9E3779B9 * 32'(i);
    end else if (ramWe) begin
      ram[ramAddr] <= ramDin;
    end
    ramDout <= ram[ramAddr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write and every valid load result must match the next expected entry.
  always @(negedge clk) begin
    if (!rst && !tbInit) begin
      if (ramWe) begin
        if (wrQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpectedWrite: got addr %h data %h expected no write", ramAddr, ramDin);
        end else begin
          monW = wrQ.pop_front();
          checkOutput("wrAddr", 32'(ramAddr), 32'(monW[41:32]));
          checkOutput("wrData", ramDin, monW[31:0]);
        end
      end
      if (rdataValid) begin
        if (ldQ.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL unexpectedLoad: got rdata %h expected no rdata_valid", rdata);
        end else begin
          monL = ldQ.pop_front();
          checkOutput("loadData", rdata, monL);
        end
      end
    end
  end

  // Issues one request, predicts its effect from the model, and holds it until stall drops.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic [ADDR_W-1:0] wa;
    logic [1:0]  off;
    logic [31:0] mask, word, val;
    logic        misal;
    int          expStall, stalls, shift;
    wa    = addr[ADDR_W+1:2];
    misal = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    off   = addr[1:0];
    if (size[1]) off = 2'b00;
    else if (size == 2'b01) off = off & 2'b10;
    shift = 8 * int'(off);
    mask  = (size == 2'b00) ? (32'hFF << shift) : (size == 2'b01) ? (32'hFFFF << shift) : 32'hFFFFFFFF;
    word  = model[wa];
    expStall = 2;
`ifdef MISALIGN_TRAP_EN
    if (misal) expStall = 0;
`else
    misal = 1'b0;
`endif
    if (!misal) begin
      if (we) begin
        model[wa] = (word & ~mask) | ((wdata << shift) & mask);
        wrQ.push_back({wa, model[wa]});
        if (size[1]) expStall = 0;
      end else begin
        val = (word & mask) >> shift;
        if (sgn && size == 2'b00 && val[7])  val = val | 32'hFFFFFF00;
        if (sgn && size == 2'b01 && val[15]) val = val | 32'hFFFF0000;
        ldQ.push_back(val);
      end
    end
    reqValid = 1'b1; reqWe = we; reqSize = size; reqSigned = sgn; reqAddr = addr; reqWdata = wdata;
    stalls = 0;
    @(negedge clk);
    checkOutput("misalign", {31'b0, misalign}, {31'b0, misal});
    while (stall && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    checkOutput("stallCycles", 32'(stalls), 32'(expStall));
    @(posedge clk); #1;
    reqValid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tbInit = 1'b1;
    reqValid = 1'b0; reqWe = 1'b0; reqSize = 2'b00; reqSigned = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h9E3779B9 * 32'(i);
    repeat (2) @(posedge clk);
    #1 tbInit = 1'b0;
    @(negedge clk);
    checkOutput("rstRdata", rdata, 32'h0);
    checkOutput("rstOutputs", {28'b0, rdataValid, misalign, stall, ramWe}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899AABB);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    checkOutput("lbSigned", rdata, 32'hFFFFFF99);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    checkOutput("lbUnsigned", rdata, 32'h00000099);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000CAFE);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("shMerged", rdata, 32'hCAFE3344);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
`ifndef MISALIGN_TRAP_EN
    checkOutput("lwMisalAligned", rdata, 32'hCAFE3344);
`endif

    // Reset lands on the RMW cycle of a byte store: no write may escape.
    reqValid = 1'b1; reqWe = 1'b1; reqSize = 2'b00; reqSigned = 1'b0; reqAddr = 32'h11; reqWdata = 32'h77;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("rstRmwWe", {31'b0, ramWe}, 32'h0);
    checkOutput("rstRmwStall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1 rst = 1'b0; reqValid = 1'b0;
    @(negedge clk);
    checkOutput("postRstRdata", rdata, 32'h0);
    checkOutput("postRstStall", {30'b0, stall, rdataValid}, 32'h0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checkOutput("rstNoPartialWrite", rdata, 32'hCAFE3344);

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A50001);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    checkOutput("b2bLh", rdata, 32'h0000A5A5);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h4, 32'h5A5A0002);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        reqValid = 1'b0; reqWe = 1'($urandom); reqSize = 2'($urandom); reqAddr = $urandom;
        @(negedge clk);
        checkOutput("idleQuiet", {30'b0, stall, misalign}, 32'h0);
        @(posedge clk); #1;
      end
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom),
                    {20'($urandom), 4'b0, 8'($urandom_range(0, 63))}, $urandom);
    end

    repeat (3) @(posedge clk);
    checkOutput("wrQueueDrained", 32'(wrQ.size()), 32'h0);
    checkOutput("ldQueueDrained", 32'(ldQ.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: word-address width driven to the data RAM (RAM depth = 2^ADDR_W 32-bit words).
REQ-002 SHALL have port clk  in  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid  in  1: MEM-stage memory request present.
REQ-005 SHALL have port req_we  in  1: 1 = store, 0 = load.
REQ-006 SHALL have port req_size  in  2: 00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-007 SHALL have port req_signed  in  1: load sign-extends when 1, zero-extends when 0.
REQ-008 SHALL have port req_addr  in  32: byte address.
REQ-009 SHALL have port req_wdata  in  32: store data, right-justified.
REQ-010 SHALL have port stall  out  1: pipeline must hold the request stable while high.
REQ-011 SHALL have port rdata  out  32: extended load result; rdata_valid  out  1: marks it valid.
REQ-012 SHALL have port misalign  out  1: misaligned-access flag.
REQ-013 SHALL have ports ram_addr  out  ADDR_W, ram_din  out  32, ram_we  out  1, ram_dout  in  32: word-wide RAM with one write enable and synchronous read (dout valid the cycle after addr).

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RMW, DONE.
REQ-015 SHALL take ram_addr = req_addr[ADDR_W+1:2] in IDLE, and the latched word address in LOAD/RMW.
REQ-016 SHALL, in IDLE with an aligned word store, drive ram_we=1, ram_din=req_wdata, stall=0 in the same cycle and remain in IDLE.
REQ-017 SHALL, in IDLE with an aligned load, latch size/signed/addr[1:0], drive stall=1, ram_we=0, and go to LOAD.
REQ-018 SHALL, in LOAD, select the byte/halfword of ram_dout by the latched offset (little-endian: offset 0 = bits 7:0), extend per latched req_signed, register the result into rdata, drive stall=1, and go to DONE.
REQ-019 SHALL, in IDLE with an aligned byte/halfword store, latch wdata/size/offset, drive stall=1, ram_we=0, and go to RMW.
REQ-020 SHALL, in RMW, drive ram_we=1 with ram_din = ram_dout with only the addressed lane(s) replaced by the low bits of the latched wdata, drive stall=1, and go to DONE.
REQ-021 SHALL, in DONE, drive stall=0, accept no request, hold rdata_valid=1 only if the operation was a load, and return to IDLE.
REQ-022 SHALL hold rdata unchanged except when updated in LOAD.
REQ-023 SHALL keep stall=0, ram_we=0, and remain in IDLE when req_valid=0 in IDLE.
REQ-024 SHALL define misaligned as halfword with addr[0]=1 or word with addr[1:0]!=00; byte accesses are never misaligned.

Reset
REQ-025 SHALL, when rst=1, enter IDLE at the next edge and force ram_we=0, stall=0 combinationally in that cycle, including mid-LOAD and mid-RMW (no partial write).
REQ-026 SHALL reset rdata=0, rdata_valid=0, misalign=0.

Configuration
REQ-027 SHALL compile misalignment trapping only when MISALIGN_TRAP_EN is defined.
REQ-028 SHALL, with MISALIGN_TRAP_EN defined, on a misaligned request in IDLE: assert misalign=1 for that cycle, perform no RAM write, drive stall=0, and remain in IDLE.
REQ-029 SHALL, without MISALIGN_TRAP_EN, tie misalign=0 and force the offending low address bits to zero (halfword: addr[0]; word: addr[1:0]) before processing.

Verification
REQ-030 SHALL verify: sw 0xDEADBEEF @0x10 -> ram_we=1, ram_addr=4, ram_din=0xDEADBEEF same cycle, stall=0.
REQ-031 SHALL verify: RAM[4]=0x8899AABB, lb @0x12 signed -> stall high 2 cycles, DONE rdata=0xFFFFFF99, rdata_valid=1; lbu -> 0x00000099.
REQ-032 SHALL verify: RAM[4]=0x11223344, sh 0x0000CAFE @0x12 -> RMW cycle ram_we=1, ram_din=0xCAFE3344; no other write.
REQ-033 SHALL verify: rst asserted during RMW cycle of sb -> ram_we=0 that cycle, next cycle IDLE with rdata=0, stall=0.
REQ-034 SHALL verify: lw @0x13 -> with MISALIGN_TRAP_EN misalign=1, stall=0, no state change; without it, returns RAM[4].
REQ-035 SHALL verify: back-to-back sw @0x0, lh @0x2, sw @0x4 with req held while stall -> each executed exactly once, in order.
